// File: rtl/plic_pkg.sv
// Shared types and constants for the PLIC interrupt gateway.
package plic_pkg;

  // Request FSM states.
  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_REQ     = 2'd1,
    GW_SERVICE = 2'd2
  } gw_state_t;

  // Number of flops in the source synchronizer chain.
  localparam int GW_SYNC_STAGES = 2;

endpackage

// File: rtl/plic_debounce.sv
// Synchronizer plus debounce filter for a raw asynchronous source.
// The filtered level only follows the synchronized input after it has
// disagreed with the current level for DEBOUNCE_CYCLES consecutive cycles.
module plic_debounce
  import plic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLK100MHZ,
  input  logic BTNC,
  input  logic in,
  output logic out
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [GW_SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]          cnt;
  logic                      synced;

  assign synced = sync[GW_SYNC_STAGES-1];

  // Metastability chain: raw source shifts in at bit 0.
  always_ff @(posedge CLK100MHZ or posedge BTNC) begin
    if (BTNC) begin
      sync <= '0;
    end else begin
      sync <= {sync[GW_SYNC_STAGES-2:0], in};
    end
  end

  // Stability counter: any agreement restarts it, a full run of
  // disagreement commits the new level.
  always_ff @(posedge CLK100MHZ or posedge BTNC) begin
    if (BTNC) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (synced == out) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      out <= synced;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/plic_gateway.sv
// PLIC interrupt gateway: debounced button source in, single outstanding
// request out, following the claim/complete handshake.
// Optional build macro PLIC_GW_EDGE_COUNT_EN replaces the 1-bit edge
// pending flag with a saturating edge counter (MAX_PENDING).
//
// state      | meaning
// -----------+-----------------------------------------------
// GW_IDLE    | no request outstanding, watching the source
// GW_REQ     | request raised to the core, waiting for claim
// GW_SERVICE | claimed, target servicing, waiting for complete
module plic_gateway
  import plic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
`ifdef PLIC_GW_EDGE_COUNT_EN
  , parameter int MAX_PENDING = 15
`endif
) (
  input  logic CLK100MHZ,
  input  logic BTNC,
  input  logic src_i,
  input  logic edge_mode_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic req_o,
  output logic busy_o,
  output logic level_o,
  output logic drop_o
);

  gw_state_t state;
  gw_state_t state_nxt;
  logic      level;
  logic      level_q;
  logic      rise;
  logic      edge_rise;
  logic      pending;
  logic      take;

  plic_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .CLK100MHZ(CLK100MHZ),
    .BTNC     (BTNC),
    .in       (src_i),
    .out      (level)
  );

  assign level_o   = level;
  assign rise      = level & ~level_q;
  // Edges only matter in edge mode; level mode never accumulates them.
  assign edge_rise = rise & edge_mode_i;

  // One-cycle delay of the filtered level for rising-edge detection.
  always_ff @(posedge CLK100MHZ or posedge BTNC) begin
    if (BTNC) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

`ifdef PLIC_GW_EDGE_COUNT_EN
  localparam int               PEND_W   = $clog2(MAX_PENDING + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  logic [PEND_W-1:0] pend_cnt;

  // Saturating edge counter: each stored edge becomes its own request.
  always_ff @(posedge CLK100MHZ or posedge BTNC) begin
    if (BTNC) begin
      pend_cnt <= '0;
    end else if (edge_rise && !take && (pend_cnt != PEND_MAX)) begin
      pend_cnt <= pend_cnt + PEND_W'(1);
    end else if (take && !edge_rise) begin
      pend_cnt <= pend_cnt - PEND_W'(1);
    end
  end

  assign pending = (pend_cnt != '0);
  assign drop_o  = edge_rise & (pend_cnt == PEND_MAX);
`else
  logic pend;

  // Single pending edge; a new edge in the consuming cycle takes priority.
  always_ff @(posedge CLK100MHZ or posedge BTNC) begin
    if (BTNC) begin
      pend <= 1'b0;
    end else if (edge_rise) begin
      pend <= 1'b1;
    end else if (take) begin
      pend <= 1'b0;
    end
  end

  assign pending = pend;
  assign drop_o  = edge_rise & pend;
`endif

  // Request FSM state register.
  always_ff @(posedge CLK100MHZ or posedge BTNC) begin
    if (BTNC) begin
      state <= GW_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    req_o     = 1'b0;
    busy_o    = 1'b0;
    take      = 1'b0;
    case (state)
      GW_IDLE: begin
        if (edge_mode_i ? pending : level) begin
          state_nxt = GW_REQ;
          take      = edge_mode_i;
        end
      end
      GW_REQ: begin
        req_o = 1'b1;
        if (claim_i) begin
          state_nxt = GW_SERVICE;
        end
      end
      GW_SERVICE: begin
        busy_o = 1'b1;
        if (complete_i) begin
          state_nxt = GW_IDLE;
        end
      end
      default: begin
        state_nxt = GW_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_plic_gateway.sv
// Self-checking bench for plic_gateway with DEBOUNCE_CYCLES = 4.
// Expected request rise times are queued when stimulus is applied and
// matched against each observed rising edge of req_o.
module tb_plic_gateway;

  localparam int DB = 4;

  logic CLK100MHZ = 1'b0;
  logic BTNC;
  logic src_i;
  logic edge_mode_i;
  logic claim_i;
  logic complete_i;
  logic req_o;
  logic busy_o;
  logic level_o;
  logic drop_o;

  plic_gateway #(
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .CLK100MHZ  (CLK100MHZ),
    .BTNC       (BTNC),
    .src_i      (src_i),
    .edge_mode_i(edge_mode_i),
    .claim_i    (claim_i),
    .complete_i (complete_i),
    .req_o      (req_o),
    .busy_o     (busy_o),
    .level_o    (level_o),
    .drop_o     (drop_o)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int unsigned cyc = 0;
  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned drops    = 0;
  bit          req_prev = 1'b0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic expect_req(input string tag, input int unsigned at);
    exp_t e;
    e.tag = tag;
    e.at  = at;
    sb.push_back(e);
  endtask

  // One clock; sample just after the edge, match req_o rises to the queue.
  task automatic step();
    exp_t e;
    @(posedge CLK100MHZ);
    #1;
    if (drop_o) drops++;
    if (req_o && !req_prev) begin
      if (sb.size() == 0) begin
        check("req_unexpected", 32'(req_o), 0);
      end else begin
        e = sb.pop_front();
        check(e.tag, cyc, e.at);
      end
    end
    req_prev = req_o;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Clean press: long enough high and low to pass the filter both ways.
  task automatic press();
    src_i = 1'b1;
    steps(2 * DB);
    src_i = 1'b0;
    steps(2 * DB);
  endtask

  task automatic do_claim();
    claim_i = 1'b1;
    step();
    claim_i = 1'b0;
    check("claim_req", 32'(req_o), 0);
    check("claim_busy", 32'(busy_o), 1);
  endtask

  // Completion lands in IDLE one edge later; a re-request rises one after that.
  task automatic do_complete(input bit rereq, input string tag);
    complete_i = 1'b1;
    if (rereq) expect_req(tag, cyc + 2);
    step();
    complete_i = 1'b0;
    check("complete_busy", 32'(busy_o), 0);
  endtask

  initial begin
    int unsigned r;
    int unsigned n;
    int unsigned base;
    bit          any;

    BTNC        = 1'b1;
    src_i       = 1'b1;
    edge_mode_i = 1'b0;
    claim_i     = 1'b0;
    complete_i  = 1'b0;

    // Reset with the source already high.
    #50;
    check("rst_req", 32'(req_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_level", 32'(level_o), 0);
    check("rst_drop", 32'(drop_o), 0);
    step();
    BTNC = 1'b0;
    r    = cyc;
    expect_req("rst_req_rise", r + DB + 3);
    n = 0;
    while (!level_o && n < 20) begin
      step();
      n++;
    end
    check("rst_level_lat", n, DB + 2);
    steps(2);

    // Level mode: claim, service, complete, re-request while still high.
    do_claim();
    steps(2);
    check("svc_busy", 32'(busy_o), 1);
    do_complete(1'b1, "lvl_rereq");
    steps(2);
    check("lvl_req_hi", 32'(req_o), 1);
    src_i = 1'b0;
    steps(2 * DB);
    check("lvl_level_low", 32'(level_o), 0);
    do_claim();
    do_complete(1'b0, "");
    steps(4);
    check("lvl_idle_low", 32'(req_o), 0);

    // Glitch one cycle shorter than the filter.
    base  = drops;
    src_i = 1'b1;
    steps(DB - 1);
    src_i = 1'b0;
    any   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      any |= level_o | req_o;
    end
    check("glitch_level_req", 32'(any), 0);
    check("glitch_drop", drops - base, 0);

    // Edge mode: second press while the first request is still pending.
    edge_mode_i = 1'b1;
    base        = drops;
    expect_req("edge_req1", cyc + DB + 4);
    press();
    press();
    check("edge_req_held", 32'(req_o), 1);
    do_claim();
    steps(2);
    do_complete(1'b1, "edge_req2");
    steps(2);
    do_claim();
    do_complete(1'b0, "");
    steps(6);
    check("edge_drop", drops - base, 0);

    // Edge overflow: three presses during SERVICE. The first latches the
    // single pending flag and the other two are lost; the counter build
    // keeps all three.
    base = drops;
    expect_req("ovf_req0", cyc + DB + 4);
    press();
    do_claim();
    press();
    press();
    press();
`ifdef PLIC_GW_EDGE_COUNT_EN
    check("ovf_drops", drops - base, 0);
`else
    check("ovf_drops", drops - base, 2);
`endif
    do_complete(1'b1, "ovf_req1");
    steps(2);
`ifdef PLIC_GW_EDGE_COUNT_EN
    for (int i = 0; i < 2; i++) begin
      do_claim();
      do_complete(1'b1, $sformatf("ovf_req%0d", i + 2));
      steps(2);
    end
`endif
    do_claim();
    do_complete(1'b0, "");
    steps(6);
    check("ovf_idle_low", 32'(req_o), 0);

    // Claim and complete together in REQ: complete is ignored.
    expect_req("sim_req", cyc + DB + 4);
    press();
    claim_i    = 1'b1;
    complete_i = 1'b1;
    step();
    claim_i    = 1'b0;
    complete_i = 1'b0;
    check("sim_busy", 32'(busy_o), 1);
    check("sim_req_low", 32'(req_o), 0);
    steps(2);
    check("sim_busy_hold", 32'(busy_o), 1);

    // Asynchronous reset in SERVICE with an edge pending and level high.
    src_i = 1'b1;
    steps(2 * DB);
    check("pre_rst_level", 32'(level_o), 1);
    #3;
    BTNC = 1'b1;
    #2;
    check("arst_req", 32'(req_o), 0);
    check("arst_busy", 32'(busy_o), 0);
    check("arst_level", 32'(level_o), 0);
    check("arst_drop", 32'(drop_o), 0);
    src_i = 1'b0;
    step();
    BTNC = 1'b0;
    steps(20);
    check("post_rst_idle", 32'(req_o), 0);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
